seg7_scan_ctrl: RTL and testbench

SEG7_SCAN_CTRL -- requirements
Module: seg7_scan_ctrl

---
 rtl/seg7_scan_ctrl.sv | 165 ++++++++++++++++
 tb/tb_seg7_scan_ctrl.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/seg7_scan_ctrl.sv
// Four-digit multiplexed seven-segment scan controller with frame-synchronous
// display updates, leading-zero suppression and global blanking.
module seg7_scan_ctrl #(
    parameter int REFRESH_DIV = 100000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] value_in,
    input  logic        load,
    input  logic        blank,
    input  logic        lz_en,
    output logic [3:0]  an,
    output logic [6:0]  seg,
    output logic [1:0]  digit_idx,
    output logic        frame_done,
    output logic        load_pending
);

    localparam int CW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CW-1:0] DIV_LAST = CW'(REFRESH_DIV - 1);

    typedef enum logic [1:0] {
        SCAN_D0 = 2'd0,
        SCAN_D1 = 2'd1,
        SCAN_D2 = 2'd2,
        SCAN_D3 = 2'd3
    } scan_t;

    logic [CW-1:0] div_cnt, div_cnt_n;
    scan_t         scan, scan_n;
    logic [15:0]   disp_reg, disp_n;
    logic [15:0]   pend_reg, pend_n;
    logic          pend_valid, pend_valid_n;
    logic          post_rst;

    logic          tick;
    logic          boundary;
    logic [3:0]    nibble;
    logic          lead_zero;
    logic          dark;
    logic [3:0]    an_n;
    logic [6:0]    seg_n;

    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt      <= '0;
            scan         <= SCAN_D0;
            disp_reg     <= '0;
            pend_reg     <= '0;
            pend_valid   <= 1'b0;
            post_rst     <= 1'b1;
            an           <= 4'b1111;
            seg          <= 7'b1111111;
            digit_idx    <= 2'd0;
            frame_done   <= 1'b0;
        end else begin
            div_cnt      <= div_cnt_n;
            scan         <= scan_n;
            disp_reg     <= disp_n;
            pend_reg     <= pend_n;
            pend_valid   <= pend_valid_n;
            post_rst     <= 1'b0;
            // Outputs stay dark for one extra cycle so reset is visibly clean.
            if (post_rst) begin
                an         <= 4'b1111;
                seg        <= 7'b1111111;
                digit_idx  <= 2'd0;
                frame_done <= 1'b0;
            end else begin
                an         <= an_n;
                seg        <= seg_n;
                digit_idx  <= scan;
                frame_done <= boundary;
            end
        end
    end

    assign load_pending = pend_valid;

    always_comb begin
        tick         = (div_cnt == DIV_LAST);
        boundary     = tick && (scan == SCAN_D3);
        div_cnt_n    = tick ? '0 : div_cnt + CW'(1);
        scan_n       = tick ? scan_t'(scan + 2'd1) : scan;
        disp_n       = disp_reg;
        pend_n       = pend_reg;
        pend_valid_n = pend_valid;

        // A load landing exactly on the boundary bypasses the pending stage.
        if (boundary) begin
            if (load) begin
                disp_n = value_in;
                pend_n = value_in;
            end else if (pend_valid) begin
                disp_n = pend_reg;
            end
            pend_valid_n = 1'b0;
        end else if (load) begin
            pend_n       = value_in;
            pend_valid_n = 1'b1;
        end
    end

    always_comb begin
        nibble    = 4'h0;
        lead_zero = 1'b0;
        case (scan)
            SCAN_D0: begin
                nibble    = disp_reg[3:0];
                lead_zero = 1'b0;
            end
            SCAN_D1: begin
                nibble    = disp_reg[7:4];
                lead_zero = (disp_reg[15:4] == 12'h000);
            end
            SCAN_D2: begin
                nibble    = disp_reg[11:8];
                lead_zero = (disp_reg[15:8] == 8'h00);
            end
            SCAN_D3: begin
                nibble    = disp_reg[15:12];
                lead_zero = (disp_reg[15:12] == 4'h0);
            end
            default: begin
                nibble    = 4'h0;
                lead_zero = 1'b0;
            end
        endcase
    end

    always_comb begin
        dark  = blank || (lz_en && lead_zero);
        an_n  = 4'b1111;
        seg_n = 7'b1111111;
        if (!dark) begin
            case (scan)
                SCAN_D0: an_n = 4'b1110;
                SCAN_D1: an_n = 4'b1101;
                SCAN_D2: an_n = 4'b1011;
                SCAN_D3: an_n = 4'b0111;
                default: an_n = 4'b1111;
            endcase
            case (nibble)
                4'h0:    seg_n = 7'b0000001;
                4'h1:    seg_n = 7'b1001111;
                4'h2:    seg_n = 7'b0010010;
                4'h3:    seg_n = 7'b0000110;
                4'h4:    seg_n = 7'b1001100;
                4'h5:    seg_n = 7'b0100100;
                4'h6:    seg_n = 7'b0100000;
                4'h7:    seg_n = 7'b0001111;
                4'h8:    seg_n = 7'b0000000;
                4'h9:    seg_n = 7'b0000100;
                4'hA:    seg_n = 7'b0001000;
                4'hB:    seg_n = 7'b1100000;
                4'hC:    seg_n = 7'b0110001;
                4'hD:    seg_n = 7'b1000010;
                4'hE:    seg_n = 7'b0110000;
                4'hF:    seg_n = 7'b0111000;
                default: seg_n = 7'b1111111;
            endcase
        end
    end

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Self-checking bench for seg7_scan_ctrl: directed scenarios plus random
// traffic compared cycle by cycle against a frame-level reference model.
module tb_seg7_scan_ctrl;

    localparam int DIV   = 4;
    localparam int FRAME = 4 * DIV;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] value_in = 16'h0000;
    logic        load = 1'b0;
    logic        blank = 1'b0;
    logic        lz_en = 1'b0;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic [1:0]  digit_idx;
    logic        frame_done;
    logic        load_pending;

    int checks = 0;
    int errors = 0;

    logic [6:0] hexTab [16] = '{
        7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
        7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
        7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
        7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
    };

    // Reference state: position within the frame plus display/pending values.
    int          phase = 0;
    logic [15:0] mDisp = 16'h0000;
    logic [15:0] mPend = 16'h0000;
    bit          mPending = 1'b0;
    bit          mPost = 1'b0;
    logic [3:0]  expAn = 4'hF;
    logic [6:0]  expSeg = 7'h7F;
    logic [1:0]  expIdx = 2'd0;
    bit          expFd = 1'b0;

    seg7_scan_ctrl #(.REFRESH_DIV(DIV)) dut (
        .clk          (clk),
        .rst          (rst),
        .value_in     (value_in),
        .load         (load),
        .blank        (blank),
        .lz_en        (lz_en),
        .an           (an),
        .seg          (seg),
        .digit_idx    (digit_idx),
        .frame_done   (frame_done),
        .load_pending (load_pending)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic modelStep();
        int          d;
        logic [15:0] upper;
        bit          dark;
        bit          bnd;
        if (rst) begin
            phase    = 0;
            mDisp    = 16'h0000;
            mPend    = 16'h0000;
            mPending = 1'b0;
            mPost    = 1'b1;
            expAn    = 4'hF;
            expSeg   = 7'h7F;
            expIdx   = 2'd0;
            expFd    = 1'b0;
        end else begin
            bnd   = (phase == FRAME - 1);
            d     = phase / DIV;
            upper = mDisp >> (4 * d);
            dark  = blank || (lz_en && d > 0 && upper == 16'h0000);
            if (mPost) begin
                expAn  = 4'hF;
                expSeg = 7'h7F;
                expIdx = 2'd0;
                expFd  = 1'b0;
            end else begin
                expIdx = 2'(d);
                expFd  = bnd;
                expAn  = dark ? 4'hF : 4'(~(32'd1 << d));
                expSeg = dark ? 7'h7F : hexTab[upper[3:0]];
            end
            if (bnd) begin
                if (load) mDisp = value_in;
                else if (mPending) mDisp = mPend;
                mPending = 1'b0;
            end else if (load) begin
                mPend    = value_in;
                mPending = 1'b1;
            end
            phase = (phase + 1) % FRAME;
            mPost = 1'b0;
        end
    endtask

    task automatic applyStimulus(input bit r, input bit ld, input logic [15:0] v,
                                 input bit bl, input bit lz);
        @(negedge clk);
        rst      = r;
        load     = ld;
        value_in = v;
        blank    = bl;
        lz_en    = lz;
        @(posedge clk);
        modelStep();
        #1;
        checkOutput("an", 32'(an), 32'(expAn));
        checkOutput("seg", 32'(seg), 32'(expSeg));
        checkOutput("digit_idx", 32'(digit_idx), 32'(expIdx));
        checkOutput("frame_done", 32'(frame_done), 32'(expFd));
        checkOutput("load_pending", 32'(load_pending), 32'(mPending));
    endtask

    task automatic idle(input int n, input bit bl, input bit lz);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 16'h0000, bl, lz);
    endtask

    // Step until the next edge will be a frame boundary; bounded by one frame.
    task automatic waitBoundary(input bit lz);
        for (int i = 0; i <= FRAME && phase != FRAME - 1; i++) idle(1, 1'b0, lz);
        checkOutput("boundary_reached", 32'(phase), 32'(FRAME - 1));
    endtask

    initial begin
        bit          r;
        bit          ld;
        bit          bl;
        bit          lz;
        logic [15:0] v;

        applyStimulus(1'b1, 1'b0, 16'h0000, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 16'h0000, 1'b0, 1'b0);
        checkOutput("reset_an", 32'(an), 32'hF);
        applyStimulus(1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);
        checkOutput("post_reset_seg", 32'(seg), 32'h7F);
        applyStimulus(1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);
        checkOutput("first_digit_an", 32'(an), 32'b1110);
        checkOutput("first_digit_seg", 32'(seg), 32'b0000001);

        idle(2 * FRAME, 1'b0, 1'b0);

        idle(5, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1, 16'h12AF, 1'b0, 1'b0);
        checkOutput("pending_after_load", 32'(load_pending), 32'd1);
        idle(2 * FRAME, 1'b0, 1'b0);

        applyStimulus(1'b0, 1'b1, 16'h0005, 1'b0, 1'b1);
        idle(2 * FRAME + 2, 1'b0, 1'b1);
        applyStimulus(1'b0, 1'b1, 16'h0000, 1'b0, 1'b1);
        idle(2 * FRAME + 2, 1'b0, 1'b1);

        idle(3, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1, 16'h1111, 1'b0, 1'b0);
        idle(2, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1, 16'h2222, 1'b0, 1'b0);
        idle(2 * FRAME, 1'b0, 1'b0);

        waitBoundary(1'b0);
        applyStimulus(1'b0, 1'b1, 16'hC3D4, 1'b0, 1'b0);
        checkOutput("boundary_load_pending", 32'(load_pending), 32'd0);
        idle(FRAME + 2, 1'b0, 1'b0);

        idle(20, 1'b1, 1'b0);
        idle(FRAME + 3, 1'b0, 1'b0);

        while (phase / DIV != 2) idle(1, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1, 16'hBEEF, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b1, 16'h7777, 1'b0, 1'b0);
        checkOutput("rst_load_pending", 32'(load_pending), 32'd0);
        idle(2 * FRAME + 2, 1'b0, 1'b0);

        lz = 1'b0;
        bl = 1'b0;
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 49) == 0) lz = ~lz;
            if ($urandom_range(0, 39) == 0) bl = ~bl;
            r  = ($urandom_range(0, 299) == 0);
            ld = ($urandom_range(0, 7) == 0);
            v  = 16'($urandom) & {{4{$urandom_range(0, 1) == 1}}, {4{$urandom_range(0, 1) == 1}},
                                  {4{$urandom_range(0, 1) == 1}}, 4'hF};
            applyStimulus(r, ld, v, bl, lz);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
